// File: rtl/lab3_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package lab3_sub_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/half_sub_cell.sv
// Half subtractor: difference and borrow of x - y.
module half_sub_cell (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/lab3_serial_sub.sv
// Bit-serial A - B, LSB first, one bit per clock through two half-subtractor stages.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module lab3_serial_sub
    import lab3_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             br;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;

    logic d1, bo1, d, bo2, bnext;
    logic accept;

    half_sub_cell u_stage1 (
        .x  (sa[0]),
        .y  (sb[0]),
        .d  (d1),
        .bo (bo1)
    );

    half_sub_cell u_stage2 (
        .x  (d1),
        .y  (br),
        .d  (d),
        .bo (bo2)
    );

    assign bnext  = bo1 | bo2;
    assign accept = (state == IDLE) && start;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb, b_msb;
`endif

    // Operand and result shift registers carry no reset: they are only
    // observed through diff, which is loaded at completion.
    always_ff @(posedge clk) begin
        if (accept) begin
            sa <= a;
            sb <= b;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            sa <= {1'b0, sa[WIDTH-1:1]};
            sb <= {1'b0, sb[WIDTH-1:1]};
            sr <= {d, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        br    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    br  <= bnext;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // The final bit goes straight into diff's MSB alongside the shifted partial result.
                        diff  <= {d, sr[WIDTH-1:1]};
                        bout  <= bnext;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab3_serial_sub.sv
// Scoreboard bench for lab3_serial_sub: directed operand pairs, monitor checks each done.
module tb_lab3_serial_sub;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   last_done = -100;
    int   prev_done = -200;

    lab3_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic bo, input logic ov);
        exp_t e;
        e.diff = d;
        e.bout = bo;
        e.ovf  = ov;
        sb_q.push_back(e);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [WIDTH-1:0] d, input logic bo, input logic ov);
        tick();
        a = av;
        b = bv;
        start = 1'b1;
        push(d, bo, ov);
        tick();
        start = 1'b0;
        repeat (WIDTH + 3) tick();
    endtask

    // Monitor: samples on the falling edge, pops one expectation per done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: diff=%0h bout=%0b with empty scoreboard", diff, bout);
                    end else begin
                        e = sb_q.pop_front();
                        check("diff", 32'(diff), 32'(e.diff));
                        check("bout", 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                        check("busy_cycles", 32'(busy_cnt), 32'(WIDTH));
                        check("busy_in_done", 32'(busy), 32'd0);
                    end
                    busy_cnt  = 0;
                    prev_done = last_done;
                    last_done = cyc;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        // Second start mid-operation must be ignored.
        tick();
        a = 8'h40;
        b = 8'h10;
        start = 1'b1;
        push(8'h30, 1'b0, 1'b0);
        tick();
        start = 1'b0;
        repeat (2) tick();
        a = 8'hFF;
        b = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (WIDTH + 3) tick();

        // Start held high: two results, done pulses WIDTH+1 apart.
        tick();
        a = 8'h09;
        b = 8'h04;
        start = 1'b1;
        push(8'h05, 1'b0, 1'b0);
        tick();
        a = 8'h04;
        b = 8'h09;
        push(8'hFB, 1'b1, 1'b0);
        repeat (WIDTH + 1) tick();
        start = 1'b0;
        repeat (WIDTH + 4) tick();
        check("b2b_done_spacing", 32'(last_done - prev_done), 32'(WIDTH + 1));

        // Reset during an operation discards it with no done.
        tick();
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;
        repeat (WIDTH + 6) tick();

`ifdef SERIAL_SUB_OVF_EN
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0);
`endif

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
